// File: rtl/bus_bridge_initiator_pkg.sv
// Shared constants, opcodes and FSM state type for the byte-stream bus initiator.
package bus_bridge_initiator_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned IDX_W  = 2;

    localparam logic [BYTE_W-1:0] OP_WRITE = 8'h57;
    localparam logic [BYTE_W-1:0] OP_READ  = 8'h52;
    localparam logic [BYTE_W-1:0] OP_PING  = 8'h50;

    localparam logic [BYTE_W-1:0] ACK_DEFAULT = 8'h06;
    localparam logic [BYTE_W-1:0] NAK_DEFAULT = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS,
        RESP
    } state_e;

endpackage

// File: rtl/bridge_shift4.sv
// 4-byte little-endian shift/select register with a byte counter; assembles
// command words from a byte stream and indexes captured words for output.
module bridge_shift4
    import bus_bridge_initiator_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load_en,
    input  logic [WORD_W-1:0] load_word,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              adv_en,
    output logic [WORD_W-1:0] word,
    output logic [IDX_W-1:0]  cnt
);

    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;

    // New bytes enter at the top so the first byte ends up in bits [7:0].
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load_en) begin
            word_d = load_word;
            cnt_d  = '0;
        end else if (shift_en) begin
            word_d = {byte_in, word_q[WORD_W-1:BYTE_W]};
            cnt_d  = cnt_q + IDX_W'(1);
        end else if (adv_en) begin
            cnt_d = cnt_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word = word_q;
    assign cnt  = cnt_q;

endmodule

// File: rtl/bus_bridge_initiator.sv
// Parses W/R/P byte commands, issues one word transaction on the valid/ready
// bus as a secondary master, and returns ACK/NAK or read data bytes.
module bus_bridge_initiator
    import bus_bridge_initiator_pkg::*;
#(
    parameter int unsigned       TIMEOUT  = 1024,
    parameter logic [BYTE_W-1:0] ACK_BYTE = ACK_DEFAULT,
    parameter logic [BYTE_W-1:0] NAK_BYTE = NAK_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic [WORD_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [BYTE_W-1:0] out_data_q, out_data_d;
    logic              mem_valid_q, mem_valid_d;
    logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
    logic              is_write_q, is_write_d;
    logic              err_q, err_d;
    logic              rd_resp_q, rd_resp_d;
    logic [CNT_W-1:0]  tmo_q, tmo_d;

    logic              accept;
    logic              misalign;
    logic              go_bus;
    logic              go_resp;
    logic [BYTE_W-1:0] resp_byte;

    logic              addr_clr, addr_shift;
    logic [WORD_W-1:0] addr_word;
    logic [IDX_W-1:0]  addr_cnt;
    logic              wdata_clr, wdata_shift;
    logic [WORD_W-1:0] wdata_word;
    logic [IDX_W-1:0]  wdata_cnt;
    logic              rd_load, rd_adv;
    logic [WORD_W-1:0] rd_word;
    logic [IDX_W-1:0]  rd_cnt;
    logic [IDX_W-1:0]  rd_next_idx;

    assign accept = in_valid && in_ready_q;

    bridge_shift4 u_addr (
        .clk       (clk),
        .rst       (rst),
        .clr       (addr_clr),
        .load_en   (1'b0),
        .load_word ('0),
        .shift_en  (addr_shift),
        .byte_in   (in_data),
        .adv_en    (1'b0),
        .word      (addr_word),
        .cnt       (addr_cnt)
    );

    bridge_shift4 u_wdata (
        .clk       (clk),
        .rst       (rst),
        .clr       (wdata_clr),
        .load_en   (1'b0),
        .load_word ('0),
        .shift_en  (wdata_shift),
        .byte_in   (in_data),
        .adv_en    (1'b0),
        .word      (wdata_word),
        .cnt       (wdata_cnt)
    );

    bridge_shift4 u_rdata (
        .clk       (clk),
        .rst       (rst),
        .clr       (1'b0),
        .load_en   (rd_load),
        .load_word (mem_rdata),
        .shift_en  (1'b0),
        .byte_in   ('0),
        .adv_en    (rd_adv),
        .word      (rd_word),
        .cnt       (rd_cnt)
    );

    // Command parsing, bus handshake, timeout and response sequencing.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        mem_valid_d = mem_valid_q;
        mem_wstrb_d = mem_wstrb_q;
        is_write_d  = is_write_q;
        err_d       = err_q;
        rd_resp_d   = rd_resp_q;
        tmo_d       = tmo_q;
        misalign    = 1'b0;
        go_bus      = 1'b0;
        go_resp     = 1'b0;
        resp_byte   = NAK_BYTE;
        addr_clr    = 1'b0;
        addr_shift  = 1'b0;
        wdata_clr   = 1'b0;
        wdata_shift = 1'b0;
        rd_load     = 1'b0;
        rd_adv      = 1'b0;
        rd_next_idx = rd_cnt + IDX_W'(1);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    rd_resp_d = 1'b0;
                    err_d     = !en;
                    case (in_data)
                        OP_WRITE: begin
                            is_write_d = 1'b1;
                            addr_clr   = 1'b1;
                            state_d    = ADDR;
                        end
                        OP_READ: begin
                            is_write_d = 1'b0;
                            addr_clr   = 1'b1;
                            state_d    = ADDR;
                        end
                        OP_PING: begin
                            go_resp   = 1'b1;
                            resp_byte = en ? ACK_BYTE : NAK_BYTE;
                        end
                        default: begin
                            go_resp   = 1'b1;
                            resp_byte = NAK_BYTE;
                        end
                    endcase
                end
            end
            ADDR: begin
                if (accept) begin
                    addr_shift = 1'b1;
                    if (addr_cnt == IDX_W'(3)) begin
                        // Byte 0 of the address sits in [15:8] before the last shift.
                        misalign = (addr_word[9:8] != 2'b00);
                        if (is_write_q) begin
                            err_d     = err_q || misalign;
                            wdata_clr = 1'b1;
                            state_d   = DATA;
                        end else if (err_q || misalign) begin
                            go_resp = 1'b1;
                        end else begin
                            go_bus = 1'b1;
                        end
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    wdata_shift = 1'b1;
                    if (wdata_cnt == IDX_W'(3)) begin
                        if (err_q) begin
                            go_resp = 1'b1;
                        end else begin
                            go_bus = 1'b1;
                        end
                    end
                end
            end
            BUS: begin
                // A ready on the final timeout cycle still completes normally.
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    mem_wstrb_d = '0;
                    tmo_d       = '0;
                    go_resp     = 1'b1;
                    if (is_write_q) begin
                        resp_byte = ACK_BYTE;
                    end else begin
                        rd_load   = 1'b1;
                        rd_resp_d = 1'b1;
                        resp_byte = mem_rdata[BYTE_W-1:0];
                    end
                end else if (tmo_q == CNT_W'(TIMEOUT - 1)) begin
                    mem_valid_d = 1'b0;
                    mem_wstrb_d = '0;
                    tmo_d       = '0;
                    go_resp     = 1'b1;
                end else begin
                    tmo_d = tmo_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (out_ready) begin
                    if (rd_resp_q && (rd_cnt != IDX_W'(3))) begin
                        rd_adv     = 1'b1;
                        out_data_d = rd_word[{rd_next_idx, 3'b000} +: BYTE_W];
                    end else begin
                        out_valid_d = 1'b0;
                        rd_resp_d   = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (go_bus) begin
            state_d     = BUS;
            mem_valid_d = 1'b1;
            mem_wstrb_d = is_write_q ? {STRB_W{1'b1}} : '0;
            tmo_d       = '0;
        end
        if (go_resp) begin
            state_d     = RESP;
            out_valid_d = 1'b1;
            out_data_d  = resp_byte;
        end

        in_ready_d = (state_d == IDLE) || (state_d == ADDR) || (state_d == DATA);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            mem_valid_q <= 1'b0;
            mem_wstrb_q <= '0;
            is_write_q  <= 1'b0;
            err_q       <= 1'b0;
            rd_resp_q   <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            mem_valid_q <= mem_valid_d;
            mem_wstrb_q <= mem_wstrb_d;
            is_write_q  <= is_write_d;
            err_q       <= err_d;
            rd_resp_q   <= rd_resp_d;
            tmo_q       <= tmo_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign mem_valid = mem_valid_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_addr  = addr_word;
    assign mem_wdata = wdata_word;

endmodule

// File: tb/tb_bus_bridge_initiator.sv
// Directed bench for bus_bridge_initiator: ping, write, read, error, timeout and reset cases.
module tb_bus_bridge_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    // Responder / monitor state
    int          ready_after = 0;
    int          vcyc = 0;
    int          valid_total = 0;
    int          last_len = 0;
    int          unstable = 0;
    logic [31:0] snap_addr = '0;
    logic [31:0] snap_wdata = '0;
    logic [3:0]  snap_wstrb = '0;

    bus_bridge_initiator #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Responder raises mem_ready on the ready_after-th valid cycle (0 = never).
    always @(negedge clk) begin
        if (mem_valid === 1'b1) begin
            if (vcyc == 0) begin
                snap_addr  <= mem_addr;
                snap_wdata <= mem_wdata;
                snap_wstrb <= mem_wstrb;
            end else if (mem_addr !== snap_addr || mem_wdata !== snap_wdata ||
                         mem_wstrb !== snap_wstrb) begin
                unstable <= unstable + 1;
            end
            vcyc        <= vcyc + 1;
            valid_total <= valid_total + 1;
            mem_ready   <= (ready_after != 0) && (vcyc + 1 == ready_after);
        end else begin
            if (vcyc != 0) last_len <= vcyc;
            vcyc      <= 0;
            mem_ready <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            vectors++;
            miscompares++;
            $error("FAIL send_byte: byte %h not accepted within %0d cycles", b, n);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic wait_out();
        int n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        wait_out();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk(tag, 32'(out_data), 32'(exp));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int vt0;
        int u0;
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        out_ready = 1'b0; mem_rdata = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_mem_addr",  mem_addr,       32'd0);
        chk("rst_mem_wdata", mem_wdata,      32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Ping
        vt0 = valid_total;
        send_byte(8'h50);
        expect_byte("ping", 8'h06);
        chk("ping_no_bus", 32'(valid_total - vt0), 32'd0);
        chk("ping_done", 32'(out_valid), 32'd0);

        // Write, ready on 3rd valid cycle
        ready_after = 3; u0 = unstable;
        send_byte(8'h57); send_word(32'h0000_0010); send_word(32'hDEAD_BEEF);
        expect_byte("wr_ack", 8'h06);
        chk("wr_addr",   snap_addr,        32'h0000_0010);
        chk("wr_wdata",  snap_wdata,       32'hDEAD_BEEF);
        chk("wr_wstrb",  32'(snap_wstrb),  32'hF);
        chk("wr_len",    32'(last_len),    32'd3);
        chk("wr_stable", 32'(unstable - u0), 32'd0);

        // Read 0x01000000 -> 2A 00 00 00, stall 5 cycles at byte 1
        ready_after = 2; mem_rdata = 32'h0000_002A;
        send_byte(8'h52); send_word(32'h0100_0000);
        expect_byte("rd0_b0", 8'h2A);
        wait_out();
        repeat (5) begin
            chk("rd0_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h00});
            @(negedge clk);
        end
        expect_byte("rd0_b1", 8'h00);
        expect_byte("rd0_b2", 8'h00);
        expect_byte("rd0_b3", 8'h00);
        chk("rd0_done",  32'(out_valid),  32'd0);
        chk("rd0_addr",  snap_addr,       32'h0100_0000);
        chk("rd0_wstrb", 32'(snap_wstrb), 32'h0);

        // Read with distinct bytes to pin byte order, stall at byte 1
        mem_rdata = 32'h4433_2211;
        send_byte(8'h52); send_word(32'h0000_0020);
        expect_byte("rd1_b0", 8'h11);
        wait_out();
        repeat (3) begin
            chk("rd1_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h22});
            @(negedge clk);
        end
        expect_byte("rd1_b1", 8'h22);
        expect_byte("rd1_b2", 8'h33);
        expect_byte("rd1_b3", 8'h44);
        chk("rd1_addr", snap_addr, 32'h0000_0020);
        mem_rdata = 32'h0;

        // Errors: bad opcode, misaligned read, disabled write
        vt0 = valid_total;
        send_byte(8'h41);
        expect_byte("bad_op", 8'h15);
        send_byte(8'h52); send_word(32'h0000_0003);
        expect_byte("misalign", 8'h15);
        en = 1'b0;
        send_byte(8'h57);
        en = 1'b1;
        send_word(32'h0000_0040);
        for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i));
        chk("dis_no_early", 32'(out_valid), 32'd0);
        chk("dis_in_ready", 32'(in_ready),  32'd1);
        send_byte(8'hA3);
        expect_byte("dis_nak", 8'h15);
        chk("err_no_bus", 32'(valid_total - vt0), 32'd0);

        // Timeout: no ready at all
        ready_after = 0;
        send_byte(8'h52); send_word(32'h0000_0100);
        expect_byte("tmo_nak", 8'h15);
        chk("tmo_len", 32'(last_len), 32'd16);
        send_byte(8'h50);
        expect_byte("tmo_ping", 8'h06);

        // Ready on the last timeout cycle still completes
        ready_after = 16;
        send_byte(8'h57); send_word(32'h0000_0044); send_word(32'h1234_5678);
        expect_byte("late_ack", 8'h06);
        chk("late_len",   32'(last_len), 32'd16);
        chk("late_wdata", snap_wdata,    32'h1234_5678);

        // Reset while the request is outstanding
        ready_after = 0;
        send_byte(8'h52); send_word(32'h0000_0000);
        repeat (3) @(negedge clk);
        chk("bus_active", 32'(mem_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstbus_mem_valid", 32'(mem_valid), 32'd0);
        chk("rstbus_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        send_byte(8'h50);
        expect_byte("rst_ping", 8'h06);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
